// File: rtl/depatchifier.sv
// Reassembles a patch-major pixel stream into a frame buffer and streams it back out in raster order.
// Optional framing check on in_last is enabled with the DEPATCHIFIER_ERR_EN macro.
module depatchifier #(
  parameter int CHANNEL_SIZE    = 8,
  parameter int NUM_CHANNELS    = 3,
  parameter int PIXEL_WIDTH     = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int IMG_WIDTH       = 16,
  parameter int IMG_HEIGHT      = 16,
  parameter int PATCH_SIZE      = 4,
  parameter int PATCH_SIZE_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic                   out_last,
  output logic [1:0]             state,
  output logic                   frame_err
);

  localparam int PATCHES_IN_ROW = IMG_WIDTH / PATCH_SIZE;
  localparam int PATCHES_IN_COL = IMG_HEIGHT / PATCH_SIZE;
  localparam int TOTAL_PIXELS   = IMG_WIDTH * IMG_HEIGHT;
  localparam int POS_W  = (PATCH_SIZE > 1)     ? $clog2(PATCH_SIZE)     : 1;
  localparam int PCOL_W = (PATCHES_IN_ROW > 1) ? $clog2(PATCHES_IN_ROW) : 1;
  localparam int PROW_W = (PATCHES_IN_COL > 1) ? $clog2(PATCHES_IN_COL) : 1;
  localparam int ADDR_W = (TOTAL_PIXELS > 1)   ? $clog2(TOTAL_PIXELS)   : 1;

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    DRAIN = 2'b01
  } state_t;

  state_t state_reg, state_next;

  logic [POS_W-1:0]  pos_col_reg, pos_col_next;
  logic [POS_W-1:0]  pos_row_reg, pos_row_next;
  logic [PCOL_W-1:0] patch_col_reg, patch_col_next;
  logic [PROW_W-1:0] patch_row_reg, patch_row_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;

  logic [PIXEL_WIDTH-1:0] frame_mem [TOTAL_PIXELS];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_row, wr_col, wr_addr;
  logic              pos_col_max, pos_row_max, patch_col_max, patch_row_max;
  logic              last_elem, rd_last;

  assign pos_col_max   = (pos_col_reg   == POS_W'(PATCH_SIZE - 1));
  assign pos_row_max   = (pos_row_reg   == POS_W'(PATCH_SIZE - 1));
  assign patch_col_max = (patch_col_reg == PCOL_W'(PATCHES_IN_ROW - 1));
  assign patch_row_max = (patch_row_reg == PROW_W'(PATCHES_IN_COL - 1));
  assign last_elem     = pos_col_max & pos_row_max & patch_col_max & patch_row_max;
  assign rd_last       = (rd_addr_reg == ADDR_W'(TOTAL_PIXELS - 1));

  // pos_* is always below PATCH_SIZE, so the OR is the same as an add
  assign wr_row  = (ADDR_W'(patch_row_reg) << PATCH_SIZE_LOG2) | ADDR_W'(pos_row_reg);
  assign wr_col  = (ADDR_W'(patch_col_reg) << PATCH_SIZE_LOG2) | ADDR_W'(pos_col_reg);
  assign wr_addr = ADDR_W'(wr_row * IMG_WIDTH) + wr_col;

`ifdef DEPATCHIFIER_ERR_EN
  logic frame_err_reg, frame_err_next;
  assign frame_err = frame_err_reg;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign frame_err      = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    pos_col_next   = pos_col_reg;
    pos_row_next   = pos_row_reg;
    patch_col_next = patch_col_reg;
    patch_row_next = patch_row_reg;
    rd_addr_next   = rd_addr_reg;
`ifdef DEPATCHIFIER_ERR_EN
    frame_err_next = frame_err_reg;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_en     = 1'b0;
    case (state_reg)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
`ifdef DEPATCHIFIER_ERR_EN
          if (in_last != last_elem) frame_err_next = 1'b1;
`endif
          if (last_elem) begin
            pos_col_next   = '0;
            pos_row_next   = '0;
            patch_col_next = '0;
            patch_row_next = '0;
            state_next     = DRAIN;
          end else if (!pos_col_max) begin
            pos_col_next = pos_col_reg + 1'b1;
          end else begin
            pos_col_next = '0;
            if (!pos_row_max) begin
              pos_row_next = pos_row_reg + 1'b1;
            end else begin
              pos_row_next = '0;
              if (!patch_col_max) begin
                patch_col_next = patch_col_reg + 1'b1;
              end else begin
                patch_col_next = '0;
                patch_row_next = patch_row_reg + 1'b1;
              end
            end
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rd_last) begin
            rd_addr_next = '0;
            state_next   = FILL;
          end else begin
            rd_addr_next = rd_addr_reg + 1'b1;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FILL;
      pos_col_reg   <= '0;
      pos_row_reg   <= '0;
      patch_col_reg <= '0;
      patch_row_reg <= '0;
      rd_addr_reg   <= '0;
`ifdef DEPATCHIFIER_ERR_EN
      frame_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      pos_col_reg   <= pos_col_next;
      pos_row_reg   <= pos_row_next;
      patch_col_reg <= patch_col_next;
      patch_row_reg <= patch_row_next;
      rd_addr_reg   <= rd_addr_next;
`ifdef DEPATCHIFIER_ERR_EN
      frame_err_reg <= frame_err_next;
`endif
    end
  end

  // Buffer contents are intentionally left untouched by reset
  always_ff @(posedge clk) begin
    if (wr_en) frame_mem[wr_addr] <= in_pixel;
  end

  assign out_pixel = frame_mem[rd_addr_reg];
  assign out_last  = out_valid & rd_last;
  assign state     = state_reg;

endmodule
